wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Two-master, one-slave Wishbone B4 pipelined arbiter.
- Shares the core's single external memory bus between instruction fetch (master 0, m0_) and the loadstore stage (master 1, m1_).
- Sits between those two units and the core's top-level wb_* port.
- Grants the bus per Wishbone cycle (cyc-level lock), alternates fairly under contention, and bounds outstanding pipelined requests.

Parameters:
- MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged requests on the slave bus (1..15).

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  synchronous active-high reset
- m0_wb_adr_i  input  32  fetch address
- m0_wb_dat_o  output  32  read data to fetch
- m0_wb_sel_i  input  4  fetch byte select
- m0_wb_stb_i  input  1  fetch strobe
- m0_wb_cyc_i  input  1  fetch cycle
- m0_wb_ack_o  output  1  fetch acknowledge
- m0_wb_stall_o  output  1  fetch stall
- m1_wb_adr_i  input  32  loadstore address
- m1_wb_dat_i  input  32  loadstore write data
- m1_wb_dat_o  output  32  read data to loadstore
- m1_wb_we_i  input  1  loadstore write enable
- m1_wb_sel_i  input  4  loadstore byte select
- m1_wb_stb_i  input  1  loadstore strobe
- m1_wb_cyc_i  input  1  loadstore cycle
- m1_wb_ack_o  output  1  loadstore acknowledge
- m1_wb_stall_o  output  1  loadstore stall
- wb_adr_o  output  32  bus address
- wb_dat_i  input  32  bus read data
- wb_dat_o  output  32  bus write data
- wb_we_o  output  1  bus write enable
- wb_sel_o  output  4  bus byte select
- wb_stb_o  output  1  bus strobe
- wb_ack_i  input  1  bus acknowledge
- wb_cyc_o  output  1  bus cycle
- wb_stall_i  input  1  bus stall

Behaviour:
- Clock/reset: one clock, clk_i. Reset is synchronous, active-high, on rst_i.
- State register state_q: IDLE, GRANT_M0, GRANT_M1.
- Other registers: last_q (last granted master, reset 1), count_q (outstanding, width clog2(MAX_OUTSTANDING+1), reset 0).
- Reset values: state_q=IDLE, count_q=0. In IDLE all outputs are 0 except m0_wb_stall_o=m1_wb_stall_o=1.
- IDLE transitions (registered; one cycle arbitration latency from cyc_i rise to grant):
  - only m0_wb_cyc_i high -> GRANT_M0.
  - only m1_wb_cyc_i high -> GRANT_M1.
  - both high -> the master not equal to last_q. After reset, m0 wins the first tie.
  - On entering a grant state, last_q is set to the granted master.
- GRANT_Mx, slave bus forwarding:
  - wb_adr_o, wb_sel_o, wb_cyc_o and wb_stb_o are combinationally muxed from master x.
  - wb_dat_o and wb_we_o are muxed from m1 when granted to m1, and are 0 when granted to m0 (fetch is read-only).
- GRANT_Mx, return path to the granted master:
  - mx_wb_ack_o = wb_ack_i.
  - mx_wb_dat_o = wb_dat_i.
  - mx_wb_stall_o = wb_stall_i OR (count_q == MAX_OUTSTANDING).
  - While count_q == MAX_OUTSTANDING, the arbiter forces wb_stb_o = 0.
- Non-granted master: stall_o=1, ack_o=0, dat_o=0 at all times.
- count_q update:
  - +1 on an accepted request (wb_stb_o & !wb_stall_i).
  - -1 on wb_ack_i.
  - Both in the same cycle: count unchanged.
  - wb_ack_i with count_q==0 is ignored (no underflow); the count saturates at 0.
- Grant release: granted mx_wb_cyc_i low -> next state IDLE, count_q cleared to 0. wb_cyc_o drops in the same cycle (combinational mux). Acks arriving after release are dropped.
- Back-to-back: a master holding cyc_i high keeps the grant indefinitely. Fairness applies only at IDLE.
- No combinational path from wb_ack_i or wb_stall_i to wb_stb_o or wb_cyc_o, except the registered count_q limit.
- Reset mid-cycle: next edge state_q=IDLE, count_q=0. All bus outputs are 0 on the cycle following the reset edge.

Decomposition:
- Shared package ecap5_dproc_pkg:
  - typedef for the arbiter state enum (IDLE, GRANT_M0, GRANT_M1).
  - localparams ARB_M0=0, ARB_M1=1.
- No sub-module. A single module with one mux block and one sequential block suffices.
- state_q is made public for the bench through a verilator_config block in the testbench wrapper tb_wb_arbiter.

Test Plan:
- Reset: assert rst_i for 2 cycles with both cyc_i high -> state_q=IDLE, wb_cyc_o=0, both stall_o=1. First grant goes to m0 on the cycle after rst_i falls.
- Single loadstore write:
  - Stimulus: m1 cyc/stb, adr=0x0000_1000, dat=0xDEAD_BEEF, sel=4'b1111, we=1.
  - Required: GRANT_M1 after 1 cycle; wb_adr_o=0x1000, wb_dat_o=0xDEADBEEF, wb_we_o=1.
  - Ack after 2 cycles -> m1_wb_ack_o=1, m0_wb_ack_o=0.
- Contention:
  - Stimulus: both cyc_i rise together; m0 holds cyc for 3 cycles, then drops.
  - Required: m0 granted first, m1 stalled throughout. IDLE 1 cycle, then GRANT_M1.
  - Next tie goes to m0 again.
- Outstanding limit:
  - Stimulus: m0 issues 6 pipelined stb with wb_stall_i=0 and no acks.
  - Required: exactly 4 accepted, then m0_wb_stall_o=1 and wb_stb_o=0.
  - One ack -> count 3, one more request accepted.
- Simultaneous accept and ack at count 2 -> count stays 2. Spurious ack at count 0 -> count stays 0, ack is forwarded to the granted master.
- Abort: m1 drops cyc with 2 outstanding -> wb_cyc_o=0 the same cycle, next state IDLE, count_q=0. A late ack is not seen by either master.

Source files
------------

// File: rtl/ecap5_dproc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ecap5_dproc_pkg
//  Description : Shared types and constants for the core's bus arbiter.
//                arb_state_t  - arbiter state encoding
//                ARB_M0/ARB_M1 - master indices (fetch / loadstore)
//  Revision    : 1.0 - initial release
// ============================================================================
package ecap5_dproc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_M0 = 2'd1,
        GRANT_M1 = 2'd2
    } arb_state_t;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Two-master / one-slave Wishbone B4 pipelined arbiter.
//                Master 0 is instruction fetch (read-only), master 1 is the
//                loadstore unit. The bus is granted for a whole cyc period,
//                ties alternate between masters, and the number of accepted
//                but unacknowledged requests is capped at MAX_OUTSTANDING.
//  Ports       : clk_i, rst_i        - clock, synchronous active-high reset
//                m0_wb_*             - fetch master side (slave interface)
//                m1_wb_*             - loadstore master side (slave interface)
//                wb_*                - shared external bus (master interface)
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import ecap5_dproc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
)(
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] m0_wb_adr_i,
    output logic [31:0] m0_wb_dat_o,
    input  logic [3:0]  m0_wb_sel_i,
    input  logic        m0_wb_stb_i,
    input  logic        m0_wb_cyc_i,
    output logic        m0_wb_ack_o,
    output logic        m0_wb_stall_o,

    input  logic [31:0] m1_wb_adr_i,
    input  logic [31:0] m1_wb_dat_i,
    output logic [31:0] m1_wb_dat_o,
    input  logic        m1_wb_we_i,
    input  logic [3:0]  m1_wb_sel_i,
    input  logic        m1_wb_stb_i,
    input  logic        m1_wb_cyc_i,
    output logic        m1_wb_ack_o,
    output logic        m1_wb_stall_o,

    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        wb_cyc_o,
    input  logic        wb_stall_i
);

    localparam int                 c_CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_OUTSTANDING);

    arb_state_t         state_q;
    arb_state_t         w_state_d;
    logic               last_q;
    logic               w_last_d;
    logic [c_CNT_W-1:0] count_q;
    logic [c_CNT_W-1:0] w_count_d;
    logic [c_CNT_W-1:0] w_count_upd;

    logic w_at_limit;
    logic w_accept;
    logic w_ack_valid;

    // The limit flag comes only from the registered count, so neither
    // wb_stall_i nor wb_ack_i can reach wb_stb_o combinationally.
    assign w_at_limit  = (count_q == c_CNT_MAX);
    assign w_accept    = wb_stb_o & ~wb_stall_i;
    // An ack with nothing outstanding must not underflow the counter.
    assign w_ack_valid = wb_ack_i & (count_q != '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= ARB_M1;      // makes m0 win the first tie after reset
            count_q <= '0;
        end else begin
            state_q <= w_state_d;
            last_q  <= w_last_d;
            count_q <= w_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_count_upd = count_q;
        if (w_accept && !w_ack_valid) begin
            w_count_upd = count_q + c_CNT_W'(1);
        end else if (!w_accept && w_ack_valid) begin
            w_count_upd = count_q - c_CNT_W'(1);
        end
    end

    always_comb begin
        w_state_d = state_q;
        w_last_d  = last_q;
        w_count_d = count_q;
        case (state_q)
            IDLE: begin
                w_count_d = '0;
                if (m0_wb_cyc_i && m1_wb_cyc_i) begin
                    // Contention: hand the bus to whoever did not have it last.
                    if (last_q == ARB_M0) begin
                        w_state_d = GRANT_M1;
                        w_last_d  = ARB_M1;
                    end else begin
                        w_state_d = GRANT_M0;
                        w_last_d  = ARB_M0;
                    end
                end else if (m0_wb_cyc_i) begin
                    w_state_d = GRANT_M0;
                    w_last_d  = ARB_M0;
                end else if (m1_wb_cyc_i) begin
                    w_state_d = GRANT_M1;
                    w_last_d  = ARB_M1;
                end
            end
            GRANT_M0: begin
                if (!m0_wb_cyc_i) begin
                    // Cycle ended: anything still in flight is abandoned.
                    w_state_d = IDLE;
                    w_count_d = '0;
                end else begin
                    w_count_d = w_count_upd;
                end
            end
            GRANT_M1: begin
                if (!m1_wb_cyc_i) begin
                    w_state_d = IDLE;
                    w_count_d = '0;
                end else begin
                    w_count_d = w_count_upd;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_count_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output mux
    // ------------------------------------------------------------------
    always_comb begin
        wb_adr_o      = '0;
        wb_dat_o      = '0;
        wb_we_o       = 1'b0;
        wb_sel_o      = '0;
        wb_stb_o      = 1'b0;
        wb_cyc_o      = 1'b0;
        m0_wb_dat_o   = '0;
        m0_wb_ack_o   = 1'b0;
        m0_wb_stall_o = 1'b1;
        m1_wb_dat_o   = '0;
        m1_wb_ack_o   = 1'b0;
        m1_wb_stall_o = 1'b1;
        case (state_q)
            GRANT_M0: begin
                // Fetch is read-only: wb_dat_o / wb_we_o stay at 0.
                wb_adr_o      = m0_wb_adr_i;
                wb_sel_o      = m0_wb_sel_i;
                wb_cyc_o      = m0_wb_cyc_i;
                wb_stb_o      = m0_wb_stb_i & m0_wb_cyc_i & ~w_at_limit;
                m0_wb_dat_o   = wb_dat_i;
                m0_wb_ack_o   = wb_ack_i & m0_wb_cyc_i;
                m0_wb_stall_o = wb_stall_i | w_at_limit;
            end
            GRANT_M1: begin
                wb_adr_o      = m1_wb_adr_i;
                wb_dat_o      = m1_wb_dat_i;
                wb_we_o       = m1_wb_we_i;
                wb_sel_o      = m1_wb_sel_i;
                wb_cyc_o      = m1_wb_cyc_i;
                wb_stb_o      = m1_wb_stb_i & m1_wb_cyc_i & ~w_at_limit;
                m1_wb_dat_o   = wb_dat_i;
                m1_wb_ack_o   = wb_ack_i & m1_wb_cyc_i;
                m1_wb_stall_o = wb_stall_i | w_at_limit;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
